mac_array_sequencer: RTL and testbench
======================================

// Module: mac_array_sequencer
// PURPOSE
//  Per-layer controller driving the MAC array control block. On start it fetches one 5x5 weight set from
//  weight BRAM into the weight preload chain (conv only), then per tile pops one ifmap word from the
//  preload FIFO and fires one compute cycle (MAC weight load for conv, pooling_compute for pool).
//  Sits between the layer/instruction decoder and the MAC array; also owns the per-lane enable mask.
// PARAMETERS
//  MAC_NUM            256  number of MAC lanes (width of enable)
//  BRAM_ADDRESS_WIDTH 12   weight BRAM address width
//  TILE_CNT_WIDTH     16   width of tile count / tile counter
// PORTS
//  clk                 in   1                  clock, all flops rising edge
//  rst                 in   1                  asynchronous reset, active-high
//  start               in   1                  launch layer; sampled only in IDLE
//  abort               in   1                  sync abort; return to IDLE, no done
//  cfg_operation       in   2                  2'b00 conv, 2'b01 pool; others treated as conv
//  cfg_kernel_size     in   5                  kernel size, latched and forwarded
//  cfg_weight_base     in   BRAM_ADDRESS_WIDTH first weight BRAM row
//  cfg_num_tiles       in   TILE_CNT_WIDTH     ifmap words/compute cycles this layer
//  cfg_active_macs     in   $clog2(MAC_NUM)+1  lanes to enable (0..MAC_NUM)
//  ifmaps_fifo_empty   in   1                  preload FIFO empty (FWFT FIFO)
//  ifmaps_fifo_rd_en   out  1                  FIFO pop
//  weight_bram_en      out  1                  weight BRAM read enable (1-cycle read latency)
//  weight_bram_addr    out  BRAM_ADDRESS_WIDTH weight BRAM read address
//  load_weight_preload out  1                  shift one BRAM row into preload chain
//  load_ifmaps         out  1                  capture FIFO head into MAC ifmap regs
//  load_MAC_weight     out  1                  conv compute strobe
//  pooling_compute     out  1                  pool compute strobe
//  operation           out  2                  latched cfg_operation
//  kernel_size         out  5                  latched cfg_kernel_size
//  enable              out  MAC_NUM            lane enable mask
//  busy                out  1                  high in every state except IDLE
//  done                out  1                  1-cycle pulse at layer end
//  tiles_done          out  TILE_CNT_WIDTH     compute strobes issued this layer
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (addr, counters, operation, kernel_size, enable all zero).
//  - All outputs are driven from flops/state decode only; no input->output combinational path.
//  - IDLE: start=1 latches all cfg_*; clear tiles_done; -> W_RD (conv) or IF_WAIT (pool). busy=0 in IDLE.
//  - W_RD: 5 cycles, weight_bram_en=1, addr = base+row, row 0..4, sum truncated mod 2^BRAM_ADDRESS_WIDTH.
//  - load_weight_preload = weight_bram_en delayed 1 cycle (5 pulses); W_RD -> W_DRAIN (1 cycle) -> IF_WAIT.
//  - IF_WAIT: hold while ifmaps_fifo_empty=1; else -> IF_LOAD. IF_LOAD: ifmaps_fifo_rd_en=load_ifmaps=1, -> COMPUTE.
//  - COMPUTE: 1 cycle; load_MAC_weight=1 (conv) or pooling_compute=1 (pool); tiles_done++.
//    tiles_done+1 == num_tiles -> DONE else -> IF_WAIT. Minimum 3 cycles/tile.
//  - num_tiles=0: no FIFO pops or compute strobes; conv goes W_DRAIN->DONE, pool goes IDLE->DONE.
//  - DONE: done=1 one cycle -> IDLE; tiles_done holds value until next start.
//  - enable[i]=1 for i<active_macs while busy; active_macs>MAC_NUM saturates to all ones; 0 in IDLE.
//  - abort (any non-IDLE state, priority over all transitions): -> IDLE next cycle, no done, strobes deasserted
//    that cycle; a pending delayed load_weight_preload is cancelled. abort in IDLE ignored.
//  - start while busy ignored; start and abort together in IDLE: abort ignored, start taken.
//  - rst mid-layer: immediate return to reset values; no done pulse.
// TESTING
//  - conv, base=0x010, tiles=2, FIFO never empty, start at cyc0 -> addr 0x010..0x014 cyc1-5, preload cyc2-6,
//    load_ifmaps cyc8,11, load_MAC_weight cyc9,12, done cyc13, busy cyc1-13, tiles_done=2.
//  - pool, tiles=3, FIFO never empty -> no BRAM reads; load_ifmaps cyc2,5,8; pooling_compute cyc3,6,9; done cyc10.
//  - conv tiles=1, FIFO empty until cyc20 -> stays IF_WAIT, rd_en first high cyc21, compute cyc22, done cyc23.
//  - base=0xFFE -> addr sequence 0xFFE,0xFFF,0x000,0x001,0x002; active_macs=300 -> enable all ones.
//  - abort at cyc4 of conv -> cyc5 IDLE, busy=0, no further preload/strobes, done never pulses; restart works.
//  - tiles=0 conv -> 5 preload pulses, no rd_en, done cyc7; rst at cyc3 of any layer -> all outputs 0 at once.

Source files
------------

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer
// Per-layer controller for the MAC array control block. Started by the layer decoder, it
// reads one 5x5 weight set (five BRAM rows) into the weight preload chain for conv layers,
// then for each tile pops one ifmap word from the preload FIFO and fires one compute strobe
// (load_mac_weight for conv, pooling_compute for pool). It also owns the per-lane enable mask.
//
// Ports
//   clk_i, rst_i              clock (rising edge) / asynchronous active-high reset
//   start_i, abort_i          launch a layer (IDLE only) / synchronous abort back to IDLE
//   cfg_*_i                   layer configuration, latched when start_i is taken
//   ifmaps_fifo_empty_i       first-word-fall-through preload FIFO empty flag
//   ifmaps_fifo_rd_en_o       FIFO pop
//   weight_bram_en_o/addr_o   weight BRAM read port (1-cycle read latency)
//   load_weight_preload_o     shift one BRAM row into the preload chain
//   load_ifmaps_o             capture FIFO head into the MAC ifmap registers
//   load_mac_weight_o         conv compute strobe
//   pooling_compute_o         pool compute strobe
//   operation_o/kernel_size_o latched configuration forwarded to the array
//   enable_o                  lane enable mask, lanes below active count while busy
//   busy_o, done_o            layer in progress / one-cycle end-of-layer pulse
//   tiles_done_o              compute strobes issued in the current/last layer
// Every output comes from a flop or a decode of the state register.

module mac_array_sequencer #(
  parameter int unsigned MAC_NUM            = 256,
  parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
  parameter int unsigned TILE_CNT_WIDTH     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [1:0]                    cfg_operation_i,
  input  logic [4:0]                    cfg_kernel_size_i,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] cfg_weight_base_i,
  input  logic [TILE_CNT_WIDTH-1:0]     cfg_num_tiles_i,
  input  logic [$clog2(MAC_NUM):0]      cfg_active_macs_i,
  input  logic                          ifmaps_fifo_empty_i,
  output logic                          ifmaps_fifo_rd_en_o,
  output logic                          weight_bram_en_o,
  output logic [BRAM_ADDRESS_WIDTH-1:0] weight_bram_addr_o,
  output logic                          load_weight_preload_o,
  output logic                          load_ifmaps_o,
  output logic                          load_mac_weight_o,
  output logic                          pooling_compute_o,
  output logic [1:0]                    operation_o,
  output logic [4:0]                    kernel_size_o,
  output logic [MAC_NUM-1:0]            enable_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [TILE_CNT_WIDTH-1:0]     tiles_done_o
);

  typedef enum logic [2:0] {
    StIdle, StWRd, StWDrain, StIfWait, StIfLoad, StCompute, StDone
  } state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    op_q;
  logic [4:0]                    ks_q;
  logic [BRAM_ADDRESS_WIDTH-1:0] addr_q;
  logic [TILE_CNT_WIDTH-1:0]     num_tiles_q;
  logic [TILE_CNT_WIDTH-1:0]     tiles_q;
  logic [2:0]                    row_q;
  logic                          preload_q;
  logic [MAC_NUM-1:0]            enable_q;
  logic [MAC_NUM-1:0]            lane_mask;

  logic take_start;
  logic cfg_is_pool;
  logic is_pool;
  logic last_tile;

  assign take_start  = (state_q == StIdle) && start_i;
  // Only 2'b01 selects pooling; the reserved encodings behave as conv.
  assign cfg_is_pool = (cfg_operation_i == 2'b01);
  assign is_pool     = (op_q == 2'b01);
  assign last_tile   = ((tiles_q + TILE_CNT_WIDTH'(1)) == num_tiles_q);

  // Counts above MAC_NUM naturally saturate to all lanes enabled.
  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < MAC_NUM; i++) begin
      lane_mask[i] = (i < 32'(cfg_active_macs_i));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (!cfg_is_pool)                   state_d = StWRd;
          else if (cfg_num_tiles_i == '0)     state_d = StDone;
          else                                state_d = StIfWait;
        end
      end
      StWRd:     if (row_q == 3'd4) state_d = StWDrain;
      StWDrain:  state_d = (num_tiles_q == '0) ? StDone : StIfWait;
      StIfWait:  if (!ifmaps_fifo_empty_i) state_d = StIfLoad;
      StIfLoad:  state_d = StCompute;
      StCompute: state_d = last_tile ? StDone : StIfWait;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // Abort outranks every transition but is ignored in IDLE (start wins there).
    if (abort_i && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= '0;
      ks_q        <= '0;
      addr_q      <= '0;
      num_tiles_q <= '0;
      tiles_q     <= '0;
      row_q       <= '0;
      preload_q   <= 1'b0;
      enable_q    <= '0;
    end else begin
      state_q   <= state_d;
      // BRAM data arrives one cycle after the read; abort drops the in-flight row.
      preload_q <= (state_q == StWRd) && !abort_i;
      if (take_start) begin
        op_q        <= cfg_operation_i;
        ks_q        <= cfg_kernel_size_i;
        addr_q      <= cfg_weight_base_i;
        num_tiles_q <= cfg_num_tiles_i;
        tiles_q     <= '0;
        row_q       <= '0;
        enable_q    <= lane_mask;
      end else begin
        if (state_q == StWRd) begin
          addr_q <= addr_q + BRAM_ADDRESS_WIDTH'(1);
          row_q  <= row_q + 3'd1;
        end
        if ((state_q == StCompute) && !abort_i) tiles_q <= tiles_q + TILE_CNT_WIDTH'(1);
        if (state_d == StIdle) enable_q <= '0;
      end
    end
  end

  assign ifmaps_fifo_rd_en_o   = (state_q == StIfLoad);
  assign load_ifmaps_o         = (state_q == StIfLoad);
  assign weight_bram_en_o      = (state_q == StWRd);
  assign weight_bram_addr_o    = addr_q;
  assign load_weight_preload_o = preload_q;
  assign load_mac_weight_o     = (state_q == StCompute) && !is_pool;
  assign pooling_compute_o     = (state_q == StCompute) && is_pool;
  assign operation_o           = op_q;
  assign kernel_size_o         = ks_q;
  assign enable_o              = enable_q;
  assign busy_o                = (state_q != StIdle);
  assign done_o                = (state_q == StDone);
  assign tiles_done_o          = tiles_q;

endmodule

// File: tb/tb_mac_array_sequencer.sv
module tb_mac_array_sequencer;

  localparam int MacNum = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  cfg_op;
  logic [4:0]  cfg_ks;
  logic [11:0] cfg_base;
  logic [15:0] cfg_tiles;
  logic [8:0]  cfg_active;
  logic        fifo_empty;

  logic              rd_en, bram_en, pre, ld, lmw, pc, busy, done;
  logic [11:0]       addr;
  logic [1:0]        op_o;
  logic [4:0]        ks_o;
  logic [MacNum-1:0] enable;
  logic [15:0]       tiles_done;

  mac_array_sequencer dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .start_i               (start),
    .abort_i               (abort),
    .cfg_operation_i       (cfg_op),
    .cfg_kernel_size_i     (cfg_ks),
    .cfg_weight_base_i     (cfg_base),
    .cfg_num_tiles_i       (cfg_tiles),
    .cfg_active_macs_i     (cfg_active),
    .ifmaps_fifo_empty_i   (fifo_empty),
    .ifmaps_fifo_rd_en_o   (rd_en),
    .weight_bram_en_o      (bram_en),
    .weight_bram_addr_o    (addr),
    .load_weight_preload_o (pre),
    .load_ifmaps_o         (ld),
    .load_mac_weight_o     (lmw),
    .pooling_compute_o     (pc),
    .operation_o           (op_o),
    .kernel_size_o         (ks_o),
    .enable_o              (enable),
    .busy_o                (busy),
    .done_o                (done),
    .tiles_done_o          (tiles_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues, filled by the stimulus when a layer is launched.
  logic [11:0] exp_addr[$];
  bit          exp_kind[$];   // 1 = pool strobe expected, 0 = conv strobe
  int          exp_done[$];
  logic [MacNum-1:0] exp_en;
  logic [1:0]  cur_op;
  logic [4:0]  cur_ks;

  // Per-layer event logs, cycles relative to the start cycle.
  int t0 = 0;
  int l_bram[$], l_pre[$], l_ld[$], l_cmp[$], l_done[$];
  int busy_first, busy_last;
  bit start_abort = 1'b0;

  task automatic chk(input string name, input logic [MacNum-1:0] got,
                     input logic [MacNum-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_q(input string name, input int got[$], input int exp[$]);
    bit ok;
    ok = (got.size() == exp.size());
    if (ok) foreach (exp[i]) if (got[i] != exp[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got cycles %p expected %p", name, got, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  int rel_m;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      rel_m = cyc - t0;
      if (bram_en) begin
        l_bram.push_back(rel_m);
        if (exp_addr.size() == 0) chk("bram_unexpected", 1, 0);
        else chk("bram_addr", addr, exp_addr.pop_front());
      end
      if (pre) l_pre.push_back(rel_m);
      if (ld || rd_en) begin
        l_ld.push_back(rel_m);
        chk("rd_en_eq_load_ifmaps", rd_en, ld);
        chk("pop_while_empty", rd_en & fifo_empty, 0);
      end
      if (lmw || pc) begin
        l_cmp.push_back(rel_m);
        if (exp_kind.size() == 0) chk("compute_unexpected", 1, 0);
        else chk("compute_kind", {lmw, pc}, exp_kind.pop_front() ? 2'b01 : 2'b10);
      end
      if (done) begin
        l_done.push_back(rel_m);
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("done_tiles", tiles_done, exp_done.pop_front());
          chk("done_operation", op_o, cur_op);
          chk("done_kernel_size", ks_o, cur_ks);
        end
      end
      if (busy) begin
        if (busy_first < 0) busy_first = rel_m;
        busy_last = rel_m;
        chk("enable_busy", enable, exp_en);
      end else begin
        chk("enable_idle", enable, 0);
      end
    end
  end

  task automatic flush();
    exp_addr.delete();
    exp_kind.delete();
    exp_done.delete();
  endtask

  // fifo_mode: 0 always full, 1 random pushes, 2 empty until cycle empty_until.
  task automatic run_layer(input logic [1:0] op, input logic [4:0] ks, input logic [11:0] base,
                           input logic [15:0] tiles, input logic [8:0] active,
                           input int fifo_mode, input int empty_until,
                           input int abort_at, input int rst_at);
    bit is_pool, finished, seen_done, popped, plain;
    int cnt;
    @(posedge clk);
    #1;
    cfg_op = op; cfg_ks = ks; cfg_base = base; cfg_tiles = tiles; cfg_active = active;
    start = 1'b1;
    abort = start_abort;
    t0 = cyc;
    l_bram.delete(); l_pre.delete(); l_ld.delete(); l_cmp.delete(); l_done.delete();
    busy_first = -1;
    busy_last  = -1;
    plain = (abort_at <= 0) && (rst_at <= 0);
    cur_op = op;
    cur_ks = ks;
    for (int i = 0; i < MacNum; i++) exp_en[i] = (i < int'(active));
    is_pool = (op == 2'b01);
    if (!is_pool) for (int r = 0; r < 5; r++) exp_addr.push_back(12'(base + 12'(r)));
    for (int t = 0; t < int'(tiles); t++) exp_kind.push_back(is_pool);
    if (plain) exp_done.push_back(int'(tiles));
    cnt = (fifo_mode == 0) ? 100000 : 0;
    fifo_empty = (cnt == 0);
    finished = 1'b0;
    for (int k = 1; k <= 3000 && !finished; k++) begin
      @(negedge clk);
      popped    = rd_en;
      seen_done = done;
      @(posedge clk);
      #1;
      // Scramble cfg and poke start while busy: both must be ignored mid-layer.
      cfg_op = 2'($urandom); cfg_ks = 5'($urandom); cfg_base = 12'($urandom);
      cfg_tiles = 16'($urandom); cfg_active = 9'($urandom);
      start = (plain && !seen_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = 1'b0;
      cnt = cnt - int'(popped);
      if (fifo_mode == 1 && $urandom_range(0, 2) == 0) cnt++;
      if (fifo_mode == 2 && k == empty_until) cnt = 100;
      fifo_empty = (cnt == 0);
      if (seen_done) begin
        finished = 1'b1;
      end else if (abort_at > 0 && k == abort_at) begin
        abort = 1'b1;
      end else if (abort_at > 0 && k == abort_at + 2) begin
        finished = 1'b1;
      end else if (rst_at > 0 && k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", {rd_en, bram_en, addr, pre, ld, lmw, pc, op_o, ks_o, busy, done,
                            tiles_done}, 0);
        chk("rst_enable", enable, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        finished = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!finished) begin
      chk("layer_timeout", 0, 1);
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end
    if (plain && finished) begin
      chk("tiles_done_held", tiles_done, tiles);
      chk("idle_after_done", busy, 0);
      chk("addr_queue_drained", exp_addr.size(), 0);
      chk("kind_queue_drained", exp_kind.size(), 0);
      chk("preload_count", l_pre.size(), is_pool ? 0 : 5);
    end
    flush();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int e[$];
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_op = '0; cfg_ks = '0; cfg_base = '0; cfg_tiles = '0; cfg_active = '0;
    fifo_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rd_en, bram_en, addr, pre, ld, lmw, pc, op_o, ks_o, busy, done,
                          tiles_done}, 0);
    chk("reset_enable", enable, 0);
    rst = 1'b0;

    // Conv, two tiles, FIFO always full.
    run_layer(2'b00, 5'd5, 12'h010, 16'd2, 9'd16, 0, 0, 0, 0);
    e = '{1, 2, 3, 4, 5};     check_q("t1_bram", l_bram, e);
    e = '{2, 3, 4, 5, 6};     check_q("t1_preload", l_pre, e);
    e = '{8, 11};             check_q("t1_load_ifmaps", l_ld, e);
    e = '{9, 12};             check_q("t1_compute", l_cmp, e);
    e = '{13};                check_q("t1_done", l_done, e);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_busy_last", busy_last, 13);

    // Pool, three tiles; abort together with start in IDLE must be ignored.
    start_abort = 1'b1;
    run_layer(2'b01, 5'd3, 12'h123, 16'd3, 9'd64, 0, 0, 0, 0);
    start_abort = 1'b0;
    e = {};                   check_q("t2_bram", l_bram, e);
    e = '{2, 5, 8};           check_q("t2_load_ifmaps", l_ld, e);
    e = '{3, 6, 9};           check_q("t2_compute", l_cmp, e);
    e = '{10};                check_q("t2_done", l_done, e);

    // Conv, one tile, FIFO empty until cycle 20.
    run_layer(2'b00, 5'd5, 12'h200, 16'd1, 9'd256, 2, 20, 0, 0);
    e = '{21};                check_q("t3_load_ifmaps", l_ld, e);
    e = '{22};                check_q("t3_compute", l_cmp, e);
    e = '{23};                check_q("t3_done", l_done, e);

    // Address wrap and saturated lane count.
    run_layer(2'b00, 5'd1, 12'hFFE, 16'd1, 9'd300, 0, 0, 0, 0);
    e = '{10};                check_q("t4_done", l_done, e);

    // Abort during the weight fetch, then restart.
    run_layer(2'b00, 5'd5, 12'h040, 16'd3, 9'd8, 0, 0, 4, 0);
    e = '{1, 2, 3, 4};        check_q("t5_bram", l_bram, e);
    e = '{2, 3, 4};           check_q("t5_preload", l_pre, e);
    e = {};                   check_q("t5_compute", l_cmp, e);
    e = {};                   check_q("t5_done", l_done, e);
    chk("t5_busy_last", busy_last, 4);
    run_layer(2'b10, 5'd7, 12'h050, 16'd1, 9'd1, 0, 0, 0, 0);
    e = '{10};                check_q("t5_restart_done", l_done, e);

    // Conv with zero tiles.
    run_layer(2'b00, 5'd5, 12'h300, 16'd0, 9'd100, 0, 0, 0, 0);
    e = '{2, 3, 4, 5, 6};     check_q("t6_preload", l_pre, e);
    e = {};                   check_q("t6_load_ifmaps", l_ld, e);
    e = '{7};                 check_q("t6_done", l_done, e);

    // Reset in the middle of a conv weight fetch and of a pool layer.
    run_layer(2'b00, 5'd5, 12'h0AA, 16'd4, 9'd200, 0, 0, 0, 3);
    run_layer(2'b01, 5'd2, 12'h0BB, 16'd4, 9'd20, 0, 0, 0, 3);

    // Randomized layers against the scoreboard.
    for (int n = 0; n < 20; n++) begin
      logic [1:0] rop;
      rop = 2'($urandom);
      run_layer(rop, 5'($urandom), 12'($urandom), 16'($urandom_range(0, 5)),
                9'($urandom), int'($urandom_range(0, 1)), 0, 0, 0);
      checks++;
      if (l_ld.size() != l_cmp.size()) begin
        errors++;
        $display("FAIL rand_ld_vs_compute: got %0d loads expected %0d", l_ld.size(),
                 l_cmp.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
